daq_run_controller: RTL and testbench

//  Sequences the DAQ test-data stream into the 32-bit host-read FIFO (/dev/xillybus_read_32).

---
 rtl/daq_run_controller.sv | 124 ++++++++++++
 tb/tb_daq_run_controller.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/daq_run_controller.sv
// rtl/daq_run_controller.sv - frames the DAQ test-data stream into header/data/trailer packets for the host FIFO
// Data words are paced by a divider in the bus_clk domain; FIFO-full stalls, host close aborts.
module daq_run_controller #(
    parameter int PKT_LEN  = 256,
    parameter int RATE_DIV = 3
) (
    input  logic        bus_clk,
    input  logic        reset,
    input  logic [7:0]  cfg_byte,
    input  logic        read_open,
    input  logic        fifo_full,
    output logic [31:0] fifo_din,
    output logic        fifo_wren,
    output logic        run_led,
    output logic [15:0] pkt_seq,
    output logic [15:0] stall_cnt
);

    localparam int               DIV_W     = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(RATE_DIV - 1);
    localparam logic [15:0]      LAST_WORD = 16'(PKT_LEN - 1);
    localparam logic [15:0]      PKT_LEN_W = 16'(PKT_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_TRAILER
    } state_t;

    state_t           state_q;
    logic             run_req_q;
    logic [15:0]      pkt_seq_q;
    logic [15:0]      stall_cnt_q;
    logic [15:0]      word_cnt_q;
    logic [31:0]      data_cnt_q;
    logic [DIV_W-1:0] div_cnt_q;

    logic word_valid;
    logic word_wr;
    logic word_stall;

    always_comb begin
        word_valid = (state_q == ST_HEADER) || (state_q == ST_TRAILER) ||
                     ((state_q == ST_DATA) && (div_cnt_q == DIV_LAST));
        word_wr    = word_valid && !fifo_full && read_open;
        word_stall = word_valid && fifo_full && read_open;
    end

    always_comb begin
        fifo_din = 32'h0;
        case (state_q)
            ST_HEADER:  fifo_din = {16'hA5A5, pkt_seq_q};
            ST_DATA:    fifo_din = data_cnt_q;
            ST_TRAILER: fifo_din = {16'h5A5A, PKT_LEN_W};
            default:    fifo_din = 32'h0;
        endcase
    end

    assign fifo_wren = word_wr;
    assign run_led   = (state_q != ST_IDLE);
    assign pkt_seq   = pkt_seq_q;
    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge bus_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            run_req_q   <= 1'b0;
            pkt_seq_q   <= 16'h0;
            stall_cnt_q <= 16'h0;
            word_cnt_q  <= 16'h0;
            data_cnt_q  <= 32'h0;
            div_cnt_q   <= '0;
        end else begin
            run_req_q <= (cfg_byte == 8'hFF) && read_open;
            if (!read_open) begin
                // Host closed the stream: drop the packet and restart numbering on reopen.
                state_q    <= ST_IDLE;
                pkt_seq_q  <= 16'h0;
                word_cnt_q <= 16'h0;
                data_cnt_q <= 32'h0;
                div_cnt_q  <= '0;
            end else begin
                if (word_stall && (stall_cnt_q != 16'hFFFF)) begin
                    stall_cnt_q <= stall_cnt_q + 16'd1;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (run_req_q) begin
                            state_q <= ST_HEADER;
                        end
                    end
                    ST_HEADER: begin
                        if (word_wr) begin
                            state_q    <= ST_DATA;
                            word_cnt_q <= 16'h0;
                            div_cnt_q  <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (word_wr) begin
                            data_cnt_q <= data_cnt_q + 32'd1;
                            word_cnt_q <= word_cnt_q + 16'd1;
                            div_cnt_q  <= '0;
                            if (word_cnt_q == LAST_WORD) begin
                                state_q <= ST_TRAILER;
                            end
                        end else if (div_cnt_q != DIV_LAST) begin
                            div_cnt_q <= div_cnt_q + DIV_W'(1);
                        end
                    end
                    ST_TRAILER: begin
                        if (word_wr) begin
                            pkt_seq_q <= pkt_seq_q + 16'd1;
                            state_q   <= run_req_q ? ST_HEADER : ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_daq_run_controller.sv
// tb/tb_daq_run_controller.sv - self-checking bench for daq_run_controller
// Two instances (fast and paced) share stimulus and are checked against a packet-position model.
module tb_daq_run_controller;

    localparam int L0 = 4;
    localparam int R0 = 1;
    localparam int L1 = 5;
    localparam int R1 = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cfg;
    logic        open_i;
    logic        full_i;
    logic [31:0] o_din   [2];
    logic        o_wren  [2];
    logic        o_led   [2];
    logic [15:0] o_seq   [2];
    logic [15:0] o_stall [2];

    always #5 clk = ~clk;

    daq_run_controller #(.PKT_LEN(L0), .RATE_DIV(R0)) dut0 (
        .bus_clk(clk), .reset(rst), .cfg_byte(cfg), .read_open(open_i), .fifo_full(full_i),
        .fifo_din(o_din[0]), .fifo_wren(o_wren[0]), .run_led(o_led[0]),
        .pkt_seq(o_seq[0]), .stall_cnt(o_stall[0])
    );

    daq_run_controller #(.PKT_LEN(L1), .RATE_DIV(R1)) dut1 (
        .bus_clk(clk), .reset(rst), .cfg_byte(cfg), .read_open(open_i), .fifo_full(full_i),
        .fifo_din(o_din[1]), .fifo_wren(o_wren[1]), .run_led(o_led[1]),
        .pkt_seq(o_seq[1]), .stall_cnt(o_stall[1])
    );

    int errs = 0;
    int checks = 0;

    // Model: pos -1 = idle, 0 = header, 1..L = data word, L+1 = trailer.
    int          m_len   [2] = '{L0, L1};
    int          m_rate  [2] = '{R0, R1};
    int          m_pos   [2];
    int          m_since [2];
    logic [15:0] m_seq   [2];
    logic [15:0] m_stall [2];
    logic [31:0] m_dcnt  [2];
    bit          m_req   [2];

    logic [31:0] s_din   [2];
    logic        s_wren  [2];
    logic        s_led   [2];
    logic [15:0] s_seq   [2];
    logic [15:0] s_stall [2];

    bit force_req = 0;
    bit rel_req   = 0;

    typedef struct {
        logic [7:0]  cfg;
        bit          open;
        bit          full;
        bit          wren;
        logic [31:0] din;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit m_pending(input int i);
        if (m_pos[i] == 0 || m_pos[i] == m_len[i] + 1) return 1'b1;
        if (m_pos[i] >= 1 && m_pos[i] <= m_len[i]) return (m_since[i] >= m_rate[i]);
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_word(input int i);
        if (m_pos[i] == 0) return {16'hA5A5, m_seq[i]};
        if (m_pos[i] == m_len[i] + 1) return {16'h5A5A, 16'(m_len[i])};
        return m_dcnt[i];
    endfunction

    task automatic model_check();
        for (int i = 0; i < 2; i++) begin
            bit exp_wr;
            exp_wr = m_pending(i) && !full_i && open_i;
            chk($sformatf("wren[%0d]", i), {31'h0, o_wren[i]}, {31'h0, exp_wr});
            if (exp_wr) chk($sformatf("din[%0d]", i), o_din[i], m_word(i));
            chk($sformatf("led[%0d]", i), {31'h0, o_led[i]}, {31'h0, m_pos[i] != -1});
            chk($sformatf("seq[%0d]", i), {16'h0, o_seq[i]}, {16'h0, m_seq[i]});
            chk($sformatf("stall[%0d]", i), {16'h0, o_stall[i]}, {16'h0, m_stall[i]});
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            bit req_next;
            bit pend;
            req_next = (cfg == 8'hFF) && open_i;
            pend     = m_pending(i);
            if (rst) begin
                m_pos[i] = -1; m_since[i] = 0; m_seq[i] = 0; m_dcnt[i] = 0;
                m_stall[i] = 0; req_next = 0;
            end else if (!open_i) begin
                m_pos[i] = -1; m_seq[i] = 0; m_dcnt[i] = 0;
            end else if (m_pos[i] == -1) begin
                if (m_req[i]) m_pos[i] = 0;
            end else if (pend && full_i) begin
                if (m_stall[i] != 16'hFFFF) m_stall[i] = m_stall[i] + 16'd1;
                m_since[i]++;
            end else if (pend) begin
                if (m_pos[i] == m_len[i] + 1) begin
                    m_seq[i] = m_seq[i] + 16'd1;
                    m_pos[i] = m_req[i] ? 0 : -1;
                end else begin
                    if (m_pos[i] >= 1) m_dcnt[i] = m_dcnt[i] + 32'd1;
                    m_pos[i]++;
                    m_since[i] = 1;
                end
            end else begin
                m_since[i]++;
            end
            m_req[i] = req_next;
        end
    endtask

    task automatic step(input logic [7:0] c, input bit o, input bit f, input bit r);
        @(negedge clk);
        if (rel_req) begin
            release dut0.pkt_seq_q;
            release dut1.pkt_seq_q;
            rel_req = 0;
        end
        if (force_req) begin
            force dut0.pkt_seq_q = 16'hFFFF;
            force dut1.pkt_seq_q = 16'hFFFF;
            m_seq[0] = 16'hFFFF;
            m_seq[1] = 16'hFFFF;
            force_req = 0;
            rel_req   = 1;
        end
        cfg = c; open_i = o; full_i = f; rst = r;
        #1;
        model_check();
        for (int i = 0; i < 2; i++) begin
            s_din[i] = o_din[i]; s_wren[i] = o_wren[i]; s_led[i] = o_led[i];
            s_seq[i] = o_seq[i]; s_stall[i] = o_stall[i];
        end
        @(posedge clk);
        model_update();
    endtask

    task automatic do_reset();
        step(8'h00, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        vec_t vecs[10];
        int   wr_t[$];
        int   cnt_a;
        int   cnt_b;

        vecs[0] = '{8'hFF, 1, 0, 0, 32'h0};
        vecs[1] = '{8'hFF, 1, 0, 0, 32'h0};
        vecs[2] = '{8'hFF, 1, 0, 1, 32'hA5A50000};
        vecs[3] = '{8'hFF, 1, 0, 1, 32'h0};
        vecs[4] = '{8'hFF, 1, 0, 1, 32'h1};
        vecs[5] = '{8'hFF, 1, 0, 1, 32'h2};
        vecs[6] = '{8'h00, 1, 0, 1, 32'h3};
        vecs[7] = '{8'h00, 1, 0, 1, 32'h5A5A0004};
        vecs[8] = '{8'h00, 1, 0, 0, 32'h0};
        vecs[9] = '{8'h00, 1, 0, 0, 32'h0};

        cfg = 8'h00; open_i = 1'b1; full_i = 1'b0; rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_pos[i] = -1; m_since[i] = 0; m_seq[i] = 0; m_stall[i] = 0; m_dcnt[i] = 0; m_req[i] = 0;
        end

        // Reset state
        do_reset();
        step(8'h00, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_wren[%0d]", i), {31'h0, s_wren[i]}, 32'h0);
            chk($sformatf("rst_din[%0d]", i), s_din[i], 32'h0);
            chk($sformatf("rst_led[%0d]", i), {31'h0, s_led[i]}, 32'h0);
            chk($sformatf("rst_seq[%0d]", i), {16'h0, s_seq[i]}, 32'h0);
            chk($sformatf("rst_stall[%0d]", i), {16'h0, s_stall[i]}, 32'h0);
        end

        // T1: one packet, back-to-back words
        for (int k = 0; k < 10; k++) begin
            step(vecs[k].cfg, vecs[k].open, vecs[k].full, 1'b0);
            chk($sformatf("t1_wren_%0d", k), {31'h0, s_wren[0]}, {31'h0, vecs[k].wren});
            if (vecs[k].wren) chk($sformatf("t1_din_%0d", k), s_din[0], vecs[k].din);
        end

        // T2: paced instance spacing and run_led
        do_reset();
        cnt_a = 0;
        for (int k = 0; k < 30; k++) begin
            step(8'hFF, 1, 0, 0);
            if (s_wren[1]) wr_t.push_back(k);
            if (k >= 2 && !s_led[1]) cnt_a++;
        end
        chk("t2_nwr", {31'h0, wr_t.size() >= 8}, 32'h1);
        if (wr_t.size() >= 8) begin
            chk("t2_hdr_at", 32'(wr_t[0]), 32'd2);
            chk("t2_hdr_d0", 32'(wr_t[1] - wr_t[0]), 32'd3);
            chk("t2_d0_d1", 32'(wr_t[2] - wr_t[1]), 32'd3);
            chk("t2_d3_d4", 32'(wr_t[5] - wr_t[4]), 32'd3);
            chk("t2_d4_trl", 32'(wr_t[6] - wr_t[5]), 32'd1);
            chk("t2_trl_hdr", 32'(wr_t[7] - wr_t[6]), 32'd1);
        end
        chk("t2_led_low", 32'(cnt_a), 32'd0);

        // T3: full held 5 cycles on data word 2
        do_reset();
        cnt_a = 0;
        for (int k = 0; k < 16; k++) begin
            step(8'hFF, 1, (k >= 5 && k <= 9), 0);
            if (s_wren[0] && s_din[0] == 32'h2) cnt_a++;
            if (k == 10) chk("t3_wr_after_full", {31'h0, s_wren[0]}, 32'h1);
        end
        chk("t3_word2_once", 32'(cnt_a), 32'd1);
        chk("t3_stall", {16'h0, s_stall[0]}, 32'd5);

        // T4: stop mid-DATA completes the packet
        do_reset();
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 20; k++) begin
            step((k < 4) ? 8'hFF : 8'h00, 1, 0, 0);
            if (s_wren[0] && s_din[0] == 32'h5A5A0004) cnt_a++;
            if (s_wren[0] && s_din[0][31:16] == 16'hA5A5) cnt_b++;
        end
        chk("t4_trailers", 32'(cnt_a), 32'd1);
        chk("t4_headers", 32'(cnt_b), 32'd1);
        chk("t4_idle", {31'h0, s_led[0]}, 32'h0);

        // T5: abort at word 1 of packet 1, then reopen
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step((k == 11) ? 8'h00 : 8'hFF, (k != 10), 0, 0);
            if (k == 10) chk("t5_abort_wren", {31'h0, s_wren[0]}, 32'h0);
            if (k == 11) chk("t5_idle", {31'h0, s_led[0]}, 32'h0);
            if (k == 14) chk("t5_hdr", s_din[0], 32'hA5A50000);
            if (k == 15) chk("t5_data0", s_din[0], 32'h0);
        end

        // T6: pkt_seq wrap, then reset mid-packet
        do_reset();
        force_req = 1;
        step(8'h00, 1, 0, 0);
        for (int k = 0; k < 11; k++) begin
            step(8'hFF, 1, 0, (k == 10));
            if (k == 2) chk("t6_hdr_ffff", s_din[0], 32'hA5A5FFFF);
            if (k == 8) chk("t6_hdr_0000", s_din[0], 32'hA5A50000);
        end
        step(8'h00, 1, 0, 0);
        chk("t6_rst_wren", {31'h0, s_wren[0]}, 32'h0);
        chk("t6_rst_din", s_din[0], 32'h0);
        chk("t6_rst_led", {31'h0, s_led[0]}, 32'h0);
        chk("t6_rst_seq", {16'h0, s_seq[0]}, 32'h0);
        chk("t6_rst_stall", {16'h0, s_stall[0]}, 32'h0);

        // Randomized run against the model
        begin
            logic [7:0] rc;
            bit         ro;
            rc = 8'hFF; ro = 1;
            for (int k = 0; k < 3000; k++) begin
                if ($urandom_range(0, 99) < 4) rc = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
                if ($urandom_range(0, 99) < 2) ro = !ro;
                if (!ro && $urandom_range(0, 9) < 3) ro = 1;
                step(rc, ro, ($urandom_range(0, 3) == 0), ($urandom_range(0, 499) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
